// File: rtl/energy_eval_sequencer.sv
// energy_eval_sequencer: sequences one column-chunked sigma^T J sigma energy
// evaluation (one J-chunk read per chunk), accumulates the signed block sums
// and returns the energy with an accept/reject decision against the best energy.
// Optional build macro: EVAL_PERF_CNT_EN adds the perf_evals / perf_stall counters.
module energy_eval_sequencer #(
   parameter int unsigned VECTOR_SIZE     = 256,
   parameter int unsigned J_ELEMENT_WIDTH = 4,
   parameter int unsigned J_COLS_PER_READ = 4,
   parameter int unsigned NUM_J_CHUNKS    = VECTOR_SIZE / J_COLS_PER_READ,
   parameter int unsigned BLOCK_WIDTH     = $clog2(VECTOR_SIZE) + J_ELEMENT_WIDTH
                                            + $clog2(J_COLS_PER_READ) + 2,
   parameter int unsigned ENERGY_WIDTH    = 2 * $clog2(VECTOR_SIZE) + J_ELEMENT_WIDTH + 1,
   parameter int unsigned ADDR_WIDTH      = 16,
   parameter int unsigned J_BASE_ADDR     = 0
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           clear,
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic [VECTOR_SIZE-1:0]         req_sigma,
   output logic                           mem_req_valid,
   input  logic                           mem_req_ready,
   output logic [ADDR_WIDTH-1:0]          mem_req_addr,
   input  logic                           mem_rsp_valid,
   output logic [VECTOR_SIZE-1:0]         dp_sigma,
   output logic [$clog2(VECTOR_SIZE)-1:0] dp_col_base,
   input  logic signed [BLOCK_WIDTH-1:0]  block_sum,
   output logic                           res_valid,
   input  logic                           res_ready,
   output logic signed [ENERGY_WIDTH-1:0] res_energy,
   output logic                           res_accept,
   output logic signed [ENERGY_WIDTH-1:0] best_energy,
   output logic                           busy,
   output logic                           proto_err
`ifdef EVAL_PERF_CNT_EN
   ,
   output logic [31:0]                    perf_evals,
   output logic [31:0]                    perf_stall
`endif
);

   localparam int unsigned CHUNK_W = $clog2(NUM_J_CHUNKS);
   localparam int unsigned COL_W   = $clog2(VECTOR_SIZE);
   localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(NUM_J_CHUNKS - 1);
   localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(J_BASE_ADDR);
   localparam logic signed [ENERGY_WIDTH-1:0] ENERGY_MAX = {1'b0, {(ENERGY_WIDTH-1){1'b1}}};

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_RESULT} state_t;

   state_t                     state_q;
   logic [CHUNK_W-1:0]         chunk_q;
   logic signed [ENERGY_WIDTH-1:0] acc_q;
   logic                       req_ready_q, mem_req_valid_q, res_valid_q, res_accept_q;
   logic                       busy_q, proto_err_q;
   logic [ADDR_WIDTH-1:0]      addr_q;
   logic [VECTOR_SIZE-1:0]     sigma_q;
   logic [COL_W-1:0]           col_base_q;
   logic signed [ENERGY_WIDTH-1:0] res_energy_q, best_q;

   logic signed [ENERGY_WIDTH-1:0] acc_d;
   logic                       accept_d;
   logic [CHUNK_W-1:0]         chunk_d;
   logic [ADDR_WIDTH-1:0]      addr_d;
   logic [COL_W-1:0]           col_base_d;

   // Running sum with the sign-extended block sum and next-chunk steering values.
   always_comb begin
      acc_d      = acc_q + ENERGY_WIDTH'(block_sum);
      accept_d   = (acc_d < best_q);
      chunk_d    = chunk_q + CHUNK_W'(1);
      addr_d     = BASE_ADDR + ADDR_WIDTH'(chunk_d);
      col_base_d = COL_W'(32'(chunk_d) * J_COLS_PER_READ);
   end

   // Sequencer FSM with registered handshake and result outputs; clear overrides all.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= S_IDLE;
         chunk_q         <= '0;
         acc_q           <= '0;
         req_ready_q     <= 1'b1;
         mem_req_valid_q <= 1'b0;
         addr_q          <= BASE_ADDR;
         sigma_q         <= '0;
         col_base_q      <= '0;
         res_valid_q     <= 1'b0;
         res_energy_q    <= '0;
         res_accept_q    <= 1'b0;
         best_q          <= ENERGY_MAX;
         busy_q          <= 1'b0;
         proto_err_q     <= 1'b0;
      end else if (clear) begin
         state_q         <= S_IDLE;
         req_ready_q     <= 1'b1;
         mem_req_valid_q <= 1'b0;
         res_valid_q     <= 1'b0;
         best_q          <= ENERGY_MAX;
         busy_q          <= 1'b0;
         proto_err_q     <= 1'b0;
      end else begin
         if (mem_rsp_valid && (state_q != S_WAIT)) proto_err_q <= 1'b1;
         unique case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  sigma_q         <= req_sigma;
                  acc_q           <= '0;
                  chunk_q         <= '0;
                  addr_q          <= BASE_ADDR;
                  col_base_q      <= '0;
                  mem_req_valid_q <= 1'b1;
                  req_ready_q     <= 1'b0;
                  busy_q          <= 1'b1;
                  state_q         <= S_FETCH;
               end
            end
            S_FETCH: begin
               if (mem_req_ready) begin
                  mem_req_valid_q <= 1'b0;
                  state_q         <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (mem_rsp_valid) begin
                  acc_q <= acc_d;
                  if (chunk_q == LAST_CHUNK) begin
                     res_energy_q <= acc_d;
                     res_accept_q <= accept_d;
                     if (accept_d) best_q <= acc_d;
                     res_valid_q  <= 1'b1;
                     state_q      <= S_RESULT;
                  end else begin
                     chunk_q         <= chunk_d;
                     addr_q          <= addr_d;
                     col_base_q      <= col_base_d;
                     mem_req_valid_q <= 1'b1;
                     state_q         <= S_FETCH;
                  end
               end
            end
            S_RESULT: begin
               if (res_ready) begin
                  res_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ready     = req_ready_q;
   assign mem_req_valid = mem_req_valid_q;
   assign mem_req_addr  = addr_q;
   assign dp_sigma      = sigma_q;
   assign dp_col_base   = col_base_q;
   assign res_valid     = res_valid_q;
   assign res_energy    = res_energy_q;
   assign res_accept    = res_accept_q;
   assign best_energy   = best_q;
   assign busy          = busy_q;
   assign proto_err     = proto_err_q;

`ifdef EVAL_PERF_CNT_EN
   logic [31:0] perf_evals_q, perf_stall_q;

   // Completed result handshakes and memory stall cycles, wrapping at 2^32.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_evals_q <= '0;
         perf_stall_q <= '0;
      end else if (clear) begin
         perf_evals_q <= '0;
         perf_stall_q <= '0;
      end else begin
         if ((state_q == S_RESULT) && res_ready) perf_evals_q <= perf_evals_q + 32'd1;
         if (((state_q == S_FETCH) && !mem_req_ready) ||
             ((state_q == S_WAIT) && !mem_rsp_valid))
            perf_stall_q <= perf_stall_q + 32'd1;
      end
   end

   assign perf_evals = perf_evals_q;
   assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_energy_eval_sequencer.sv
// Directed bench for energy_eval_sequencer (VECTOR_SIZE=8, J_COLS_PER_READ=2)
// with a bench-driven memory and an expected-result scoreboard.
module tb_energy_eval_sequencer;

   localparam int EMAX = 1023;

   logic              clk = 1'b0;
   logic              rst_n, clear, req_valid, req_ready;
   logic [7:0]        req_sigma, dp_sigma;
   logic              mem_req_valid, mem_req_ready, mem_rsp_valid;
   logic [15:0]       mem_req_addr;
   logic [2:0]        dp_col_base;
   logic signed [9:0] block_sum;
   logic              res_valid, res_ready, res_accept, busy, proto_err;
   logic signed [10:0] res_energy, best_energy;
`ifdef EVAL_PERF_CNT_EN
   logic [31:0]       perf_evals, perf_stall;
`endif

   energy_eval_sequencer #(.VECTOR_SIZE(8), .J_COLS_PER_READ(2)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .req_valid(req_valid), .req_ready(req_ready), .req_sigma(req_sigma),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid),
      .dp_sigma(dp_sigma), .dp_col_base(dp_col_base), .block_sum(block_sum),
      .res_valid(res_valid), .res_ready(res_ready), .res_energy(res_energy),
      .res_accept(res_accept), .best_energy(best_energy), .busy(busy),
      .proto_err(proto_err)
`ifdef EVAL_PERF_CNT_EN
      , .perf_evals(perf_evals), .perf_stall(perf_stall)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int energy;
      bit accept;
      int best;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   best_m  = EMAX;
   int   sums[4];
   int   rdy_w[4];
   int   rsp_w[4];

   task automatic chk(input string tag, input logic signed [63:0] obs,
                      input logic signed [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_reset();
      chk("rst_req_ready", req_ready, 1);
      chk("rst_mem_req_valid", mem_req_valid, 0);
      chk("rst_addr", mem_req_addr, 0);
      chk("rst_dp_sigma", dp_sigma, 0);
      chk("rst_col_base", dp_col_base, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_energy", res_energy, 0);
      chk("rst_res_accept", res_accept, 0);
      chk("rst_best", best_energy, EMAX);
      chk("rst_busy", busy, 0);
      chk("rst_proto_err", proto_err, 0);
   endtask

   // One evaluation; abort_chunk>=0 aborts it there by clear (WAIT) or reset (FETCH).
   task automatic run_eval(input int hold, input int abort_chunk, input bit abort_rst,
                           input bit try_req);
      logic [7:0] sigma;
      int t0, stall, e;
      bit acc;
      exp_t x;
      sigma = 8'($urandom);
      stall = 0;
      e = 0;
      for (int i = 0; i < 4; i++) begin
         stall += rdy_w[i] + rsp_w[i];
         e += sums[i];
      end
      if (abort_chunk < 0) begin
         acc = (e < best_m);
         if (acc) best_m = e;
         sb.push_back('{e, acc, best_m});
      end
      chk("idle_req_ready", req_ready, 1);
      req_valid = 1'b1;
      req_sigma = sigma;
      t0 = cyc;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         chk("fetch_valid", mem_req_valid, 1);
         chk("fetch_addr", mem_req_addr, c);
         chk("fetch_col_base", dp_col_base, 2 * c);
         chk("busy", busy, 1);
         if (c == 0) chk("dp_sigma", dp_sigma, sigma);
         if (abort_rst && c == abort_chunk) begin
            rst_n = 1'b0;
            #1;
            check_reset();
            rst_n = 1'b1;
            best_m = EMAX;
            @(posedge clk); #1;
            return;
         end
         for (int k = 0; k < rdy_w[c]; k++) begin
            @(posedge clk); #1;
            chk("fetch_hold_valid", mem_req_valid, 1);
            chk("fetch_hold_addr", mem_req_addr, c);
         end
         mem_req_ready = 1'b1;
         @(posedge clk); #1;
         mem_req_ready = 1'b0;
         chk("wait_req_low", mem_req_valid, 0);
         if (!abort_rst && c == abort_chunk) begin
            clear = 1'b1;
            @(posedge clk); #1;
            clear = 1'b0;
            chk("clr_busy", busy, 0);
            chk("clr_req_ready", req_ready, 1);
            chk("clr_mem_req_valid", mem_req_valid, 0);
            chk("clr_res_valid", res_valid, 0);
            chk("clr_best", best_energy, EMAX);
            chk("clr_proto_err", proto_err, 0);
            best_m = EMAX;
            for (int k = 0; k < 3; k++) begin
               @(posedge clk); #1;
               chk("clr_no_result", res_valid, 0);
            end
            return;
         end
         for (int k = 0; k < rsp_w[c]; k++) begin
            @(posedge clk); #1;
         end
         chk("wait_col_base_hold", dp_col_base, 2 * c);
         chk("wait_addr_hold", mem_req_addr, c);
         mem_rsp_valid = 1'b1;
         block_sum = 10'(sums[c]);
         @(posedge clk); #1;
         mem_rsp_valid = 1'b0;
      end
      chk("res_valid_rise", res_valid, 1);
      chk("res_latency", cyc - t0, 9 + stall);
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 1, 0);
         return;
      end
      x = sb.pop_front();
      chk("res_energy", res_energy, x.energy);
      chk("res_accept", res_accept, x.accept);
      chk("best_energy", best_energy, x.best);
      for (int k = 0; k < hold; k++) begin
         if (try_req) begin
            req_valid = 1'b1;
            req_sigma = ~sigma;
         end
         @(posedge clk); #1;
         chk("hold_res_valid", res_valid, 1);
         chk("hold_res_energy", res_energy, x.energy);
         chk("hold_res_accept", res_accept, x.accept);
         chk("hold_req_ready", req_ready, 0);
         chk("hold_dp_sigma", dp_sigma, sigma);
      end
      req_valid = 1'b0;
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      chk("done_req_ready", req_ready, 1);
      chk("done_res_valid", res_valid, 0);
      chk("done_busy", busy, 0);
      chk("done_no_fetch", mem_req_valid, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; clear = 1'b0; req_valid = 1'b0; req_sigma = '0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; block_sum = '0; res_ready = 1'b0;
      rdy_w = '{0, 0, 0, 0};
      rsp_w = '{0, 0, 0, 0};
      repeat (2) @(posedge clk);
      #1;
      check_reset();
      rst_n = 1'b1;
      @(posedge clk); #1;

      sums = '{3, -1, 4, 2};    run_eval(0, -1, 0, 0);
      sums = '{5, 5, 0, 0};     run_eval(0, -1, 0, 0);
      sums = '{-4, 0, 0, 0};    run_eval(0, -1, 0, 0);

      sums = '{3, -1, 4, 2};
      rdy_w = '{0, 3, 0, 0};
      rsp_w = '{0, 0, 0, 2};
      run_eval(4, -1, 0, 1);
      rdy_w = '{0, 0, 0, 0};
      rsp_w = '{0, 0, 0, 0};
`ifdef EVAL_PERF_CNT_EN
      chk("perf_stall", perf_stall, 5);
      chk("perf_evals", perf_evals, 4);
`endif

      mem_rsp_valid = 1'b1;
      block_sum = 10'sd100;
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0;
      chk("proto_err_set", proto_err, 1);
      chk("proto_busy", busy, 0);
      chk("proto_res_energy", res_energy, 8);
      chk("proto_best", best_energy, -4);
      chk("proto_res_valid", res_valid, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("proto_err_sticky", proto_err, 1);

      sums = '{1, 1, 1, 1};     run_eval(0, 2, 0, 0);
`ifdef EVAL_PERF_CNT_EN
      chk("perf_stall_clr", perf_stall, 0);
      chk("perf_evals_clr", perf_evals, 0);
`endif
      sums = '{8, 0, 0, 0};     run_eval(0, -1, 0, 0);
      sums = '{-256, -256, -256, -256}; run_eval(1, -1, 0, 0);
      sums = '{2, 2, 2, 2};     run_eval(0, 1, 1, 0);
      sums = '{0, 0, 0, 7};     run_eval(0, -1, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/energy_eval_sequencer.md
# energy_eval_sequencer

Controller that sequences one full Ising energy evaluation through the column-chunked σᵀJσ datapath. It accepts a candidate σ vector over a valid/ready handshake and issues one J-chunk read per chunk to the weight memory. It steers the datapath's column-base index and accumulates the per-chunk signed block sums into a total energy. It then returns the energy together with an accept/reject decision against the best energy seen so far.

## Interface
- VECTOR_SIZE, 256, σ length / J matrix dimension
- J_ELEMENT_WIDTH, 4, J element bit width
- J_COLS_PER_READ, 4, J columns delivered per memory read
- NUM_J_CHUNKS, VECTOR_SIZE/J_COLS_PER_READ, reads per evaluation (power of two, ≥2)
- BLOCK_WIDTH, $clog2(VECTOR_SIZE)+J_ELEMENT_WIDTH+$clog2(J_COLS_PER_READ)+2, signed block-sum width
- ENERGY_WIDTH, 2*$clog2(VECTOR_SIZE)+J_ELEMENT_WIDTH+1, signed energy width
- ADDR_WIDTH, 16, memory address width
- J_BASE_ADDR, 0, address of chunk 0

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous abort + best-energy reset
- req_valid  in  1  candidate σ offered
- req_ready  out  1  sequencer can accept a candidate
- req_sigma  in  VECTOR_SIZE  candidate σ (bit 1 = +1, bit 0 = −1)
- mem_req_valid  out  1  chunk read request
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_WIDTH  J_BASE_ADDR + chunk index
- mem_rsp_valid  in  1  chunk data valid at datapath this cycle (one pulse per request)
- dp_sigma  out  VECTOR_SIZE  latched σ to datapath
- dp_col_base  out  $clog2(VECTOR_SIZE)  chunk index × J_COLS_PER_READ
- block_sum  in  BLOCK_WIDTH signed  datapath result for current chunk
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result
- res_energy  out  ENERGY_WIDTH signed  total energy
- res_accept  out  1  res_energy < best energy before this evaluation
- best_energy  out  ENERGY_WIDTH signed  best accepted energy
- busy  out  1  state ≠ IDLE
- proto_err  out  1  sticky: mem_rsp_valid outside WAIT

## Operation
- States: IDLE, FETCH, WAIT, RESULT.
- IDLE: req_ready=1. On req_valid, latch σ, clear accumulator, set chunk=0, and go to FETCH.
- FETCH: mem_req_valid=1. On mem_req_ready, go to WAIT. Address and dp_col_base are held until the response.
- WAIT: On mem_rsp_valid, acc += sign-extended block_sum. If chunk=NUM_J_CHUNKS−1, go to RESULT; otherwise chunk++ and go to FETCH.
- On entry to RESULT, res_energy=acc and res_accept=(acc<best, signed). If accepted, best_energy=acc in the same edge.
- RESULT: res_valid=1 until res_ready, then go to IDLE. Result outputs stay stable while res_valid=1.
- A response arriving in the same cycle as mem_req_ready in FETCH is not allowed; memory latency is ≥1 cycle.
- mem_rsp_valid in any state other than WAIT is ignored and sets proto_err. proto_err is cleared only by clear or reset.
- clear: from any state, go to IDLE. It drops mem_req_valid/res_valid, sets best_energy to the most-positive value, and clears proto_err. A pending request is abandoned; the memory side must tolerate this.
- Arithmetic: two's complement with no saturation. ENERGY_WIDTH is sized so overflow cannot occur.

## Timing
- Reset values: req_ready=1, mem_req_valid=0, mem_req_addr=J_BASE_ADDR, dp_sigma=0, dp_col_base=0, res_valid=0, res_energy=0, res_accept=0, best_energy=2^(ENERGY_WIDTH−1)−1, busy=0, proto_err=0.
- Handshake on cycle T: FETCH at T+1. With zero-wait ready and 1-cycle response, each chunk takes 2 cycles, and res_valid rises at T+2·NUM_J_CHUNKS+1.
- Memory stalls extend FETCH or WAIT cycle-for-cycle.
- res_ready held high: IDLE (req_ready=1) on the cycle after res_valid rises. No back-to-back overlap.
- Reset asserted mid-evaluation: immediate return to reset values. No partial result is emitted.

## Configuration
- EVAL_PERF_CNT_EN defined: adds outputs perf_evals (32 b, completed result handshakes) and perf_stall (32 b, cycles in FETCH with mem_req_ready=0 plus cycles in WAIT without mem_rsp_valid). Both wrap at 2^32 and are reset by rst_n or clear.
- EVAL_PERF_CNT_EN undefined: neither these ports nor the counters exist. All other behaviour is identical.

## Test plan
Test configuration: VECTOR_SIZE=8, J_COLS_PER_READ=2, NUM_J_CHUNKS=4.
- After reset, block sums 3, −1, 4, 2 on zero-wait memory → res_energy=8, res_accept=1, best_energy=8, addresses 0..3, dp_col_base 0,2,4,6, res_valid at T+9.
- Second evaluation with sums 5, 5, 0, 0 → res_energy=10, res_accept=0, best_energy stays 8. A third with sums −4, 0, 0, 0 → energy −4, accepted, best=−4.
- mem_req_ready low 3 cycles on chunk 1, response delayed 2 cycles on chunk 3 → same energy, res_valid 5 cycles later, perf_stall=5 if EVAL_PERF_CNT_EN.
- res_ready held low 4 cycles → res_valid/res_energy stable, req_ready=0 throughout; a req_valid during this time is not accepted.
- clear asserted in WAIT of chunk 2 → IDLE next cycle, no res_valid, best_energy=max positive. A following evaluation of 8 is accepted.
- mem_rsp_valid pulsed in IDLE → proto_err=1, accumulator and outputs unchanged; proto_err stays set until clear.
